// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, field positions and exception codes.
// The hazard unit and the decoder import these definitions as well.
package cp0_pkg;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    localparam logic [31:0] PRID_VALUE = 32'h0000_4D49;

    localparam int SR_IM_HI     = 15;
    localparam int SR_IM_LO     = 10;
    localparam int SR_EXL       = 1;
    localparam int SR_IE        = 0;
    localparam int CAUSE_BD     = 31;
    localparam int CAUSE_IP_HI  = 15;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_EXC_HI = 6;
    localparam int CAUSE_EXC_LO = 2;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

endpackage

// File: rtl/cp0.sv
// Coprocessor 0: status/cause/EPC/PRId registers, interrupt and exception request,
// mtc0/mfc0 access and eret handling for the M stage.
module cp0
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic [31:0] PC,
    input  logic [4:0]  ExcCode,
    input  logic        BD,
    input  logic [5:0]  HWInt,
    input  logic        We,
    input  logic        EXLClr,
    output logic        IntReq,
    output logic [31:0] EPC,
    output logic [31:0] DOut
);

    logic [5:0]  im;
    logic        exl;
    logic        ie;
    logic        cause_bd;
    logic [5:0]  ip;
    logic [4:0]  exc;
    logic [31:0] epc_reg;

    logic        int_pend;
    logic        exc_pend;
    logic [31:0] pc_adj;
    logic [31:0] epc_target;
    logic [31:0] sr_word;
    logic [31:0] cause_word;

    assign int_pend   = (|(HWInt & im)) & ie & ~exl;
    assign exc_pend   = (ExcCode != 5'd0) & ~exl;
    assign IntReq     = int_pend | exc_pend;
    // A delay-slot instruction restarts at its branch so the branch re-executes.
    assign pc_adj     = BD ? (PC - 32'd4) : PC;
    assign epc_target = pc_adj & 32'hFFFF_FFFC;
    assign EPC        = epc_reg;

    always_comb begin
        sr_word = '0;
        sr_word[SR_IM_HI:SR_IM_LO] = im;
        sr_word[SR_EXL]            = exl;
        sr_word[SR_IE]             = ie;

        cause_word = '0;
        cause_word[CAUSE_BD]                   = cause_bd;
        cause_word[CAUSE_IP_HI:CAUSE_IP_LO]    = ip;
        cause_word[CAUSE_EXC_HI:CAUSE_EXC_LO]  = exc;

        case (A1)
            CP0_SR:    DOut = sr_word;
            CP0_CAUSE: DOut = cause_word;
            CP0_EPC:   DOut = epc_reg;
            CP0_PRID:  DOut = PRID_VALUE;
            default:   DOut = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            im       <= '0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            cause_bd <= 1'b0;
            ip       <= '0;
            exc      <= '0;
            epc_reg  <= '0;
        end else begin
            ip <= HWInt;
            if (IntReq) begin
                exl      <= 1'b1;
                cause_bd <= BD;
                exc      <= int_pend ? 5'(EXC_INT) : ExcCode;
                epc_reg  <= epc_target;
            end else begin
                if (We && A2 == CP0_SR) begin
                    im  <= DIn[SR_IM_HI:SR_IM_LO];
                    ie  <= DIn[SR_IE];
                    // eret in the same cycle overrides the written EXL bit.
                    exl <= DIn[SR_EXL] & ~EXLClr;
                end else if (EXLClr) begin
                    exl <= 1'b0;
                end
                if (We && A2 == CP0_EPC)
                    epc_reg <= DIn & 32'hFFFF_FFFC;
            end
        end
    end

endmodule
